// File: rtl/rd_edge_value_pair_pkg.sv
// rtl/rd_edge_value_pair_pkg.sv - shared widths and edge-line types for the edge/value pairing stage
package rd_edge_value_pair_pkg;

  localparam int CACHELINE_LEN    = 16;
  localparam int HBM_EDGE_MASK    = CACHELINE_LEN;
  localparam int V_ID_WIDTH       = 32;
  localparam int V_VALUE_WIDTH    = 32;
  localparam int ITERATION_WIDTH  = 8;
  localparam int FIFO_AWIDTH      = 5;
  localparam int PROG_FULL_MARGIN = 8;

  typedef struct packed {
    logic [V_ID_WIDTH-1:0]               src_id;
    logic [V_VALUE_WIDTH-1:0]            value;
    logic [CACHELINE_LEN*V_ID_WIDTH-1:0] dst_ids;
    logic [HBM_EDGE_MASK-1:0]            mask;
  } edge_line_t;

  typedef struct packed {
    logic [V_ID_WIDTH-1:0]    v_id;
    logic [HBM_EDGE_MASK-1:0] mask;
    logic                     first;
  } req_entry_t;

  // A request opens a new vertex when nothing was written yet or the id changed.
  function automatic logic is_first(input logic                  last_valid,
                                    input logic [V_ID_WIDTH-1:0] last_id,
                                    input logic [V_ID_WIDTH-1:0] cur_id);
    return !last_valid || (last_id != cur_id);
  endfunction

endpackage

// File: rtl/rd_edge_value_pair_pair_fifo_ft.sv
// rtl/rd_edge_value_pair_pair_fifo_ft.sv - first-word-fall-through FIFO with free count and prog_full
module pair_fifo_ft #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 5,
  parameter int MARGIN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              empty,
  output logic              full,
  output logic              prog_full,
  output logic [AWIDTH:0]   free_cnt,
  output logic              overflow
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C  = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] MARGIN_C = (AWIDTH+1)'(MARGIN);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [AWIDTH:0]   count;
  logic              wr_ok, rd_ok;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign free_cnt  = DEPTH_C - count;
  assign prog_full = (free_cnt < MARGIN_C);
  assign rd_data   = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a write at full still lands.
  assign rd_ok    = rd_en && !empty;
  assign wr_ok    = wr_en && (!full || rd_ok);
  assign overflow = wr_en && !wr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AWIDTH{1'b0}}, wr_ok} - {{AWIDTH{1'b0}}, rd_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rd_edge_value_pair.sv
// rtl/rd_edge_value_pair.sv - pairs in-order HBM edge lines with their request's source id/value; DROP_EMPTY_LINE_EN suppresses all-zero-mask lines
module rd_edge_value_pair #(
  parameter int FIFO_AWIDTH      = 5,
  parameter int PROG_FULL_MARGIN = 8
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic [rd_edge_value_pair_pkg::HBM_EDGE_MASK-1:0]         front_rd_hbm_edge_mask,
  input  logic [rd_edge_value_pair_pkg::V_ID_WIDTH-1:0]            front_hbm_active_v_id,
  input  logic                                                     front_rd_hbm_edge_valid,
  input  logic [rd_edge_value_pair_pkg::V_VALUE_WIDTH-1:0]         front_hbm_active_v_value,
  input  logic                                                     front_hbm_active_v_value_valid,
  input  logic [rd_edge_value_pair_pkg::CACHELINE_LEN*rd_edge_value_pair_pkg::V_ID_WIDTH-1:0] hbm_edge_data,
  input  logic                                                     hbm_edge_data_valid,
  input  logic                                                     front_iteration_end,
  input  logic                                                     front_iteration_end_valid,
  input  logic [rd_edge_value_pair_pkg::ITERATION_WIDTH-1:0]       front_iteration_id,
  input  logic                                                     combine_stage_full,
  output logic                                                     stage_full,
  output logic [rd_edge_value_pair_pkg::V_ID_WIDTH-1:0]            edge_src_id,
  output logic [rd_edge_value_pair_pkg::V_VALUE_WIDTH-1:0]         edge_src_value,
  output logic [rd_edge_value_pair_pkg::CACHELINE_LEN*rd_edge_value_pair_pkg::V_ID_WIDTH-1:0] edge_dst_id,
  output logic [rd_edge_value_pair_pkg::HBM_EDGE_MASK-1:0]         edge_mask,
  output logic                                                     edge_valid,
  output logic                                                     iteration_end,
  output logic                                                     iteration_end_valid,
  output logic [rd_edge_value_pair_pkg::ITERATION_WIDTH-1:0]       iteration_id,
  output logic                                                     overflow_err
);

  import rd_edge_value_pair_pkg::*;

  localparam int REQ_W = $bits(req_entry_t);
  localparam int RSP_W = CACHELINE_LEN*V_ID_WIDTH;

  req_entry_t                req_wr, req_top;
  logic [RSP_W-1:0]          rsp_top;
  logic [V_VALUE_WIDTH-1:0]  val_top;
  logic                      req_empty, rsp_empty, val_empty;
  logic                      req_full, rsp_full, val_full;
  logic                      req_pf, rsp_pf, val_pf;
  logic                      req_ovf, rsp_ovf, val_ovf;
  logic [FIFO_AWIDTH:0]      req_free, rsp_free, val_free;

  logic                      last_valid;
  logic [V_ID_WIDTH-1:0]     last_wr_id;
  logic [V_VALUE_WIDTH-1:0]  cur_value;
  logic [V_VALUE_WIDTH-1:0]  value_sel;
  edge_line_t                out_q;
  logic                      pop, emit, fwd_end, pop_val;

  assign req_wr = '{v_id:  front_hbm_active_v_id,
                    mask:  front_rd_hbm_edge_mask,
                    first: is_first(last_valid, last_wr_id, front_hbm_active_v_id)};

  pair_fifo_ft #(.WIDTH(REQ_W), .AWIDTH(FIFO_AWIDTH), .MARGIN(PROG_FULL_MARGIN)) u_req (
    .clk(clk), .rst(rst),
    .wr_en(front_rd_hbm_edge_valid), .wr_data(req_wr),
    .rd_en(pop), .rd_data(req_top),
    .empty(req_empty), .full(req_full), .prog_full(req_pf),
    .free_cnt(req_free), .overflow(req_ovf)
  );

  pair_fifo_ft #(.WIDTH(RSP_W), .AWIDTH(FIFO_AWIDTH), .MARGIN(PROG_FULL_MARGIN)) u_rsp (
    .clk(clk), .rst(rst),
    .wr_en(hbm_edge_data_valid), .wr_data(hbm_edge_data),
    .rd_en(pop), .rd_data(rsp_top),
    .empty(rsp_empty), .full(rsp_full), .prog_full(rsp_pf),
    .free_cnt(rsp_free), .overflow(rsp_ovf)
  );

  pair_fifo_ft #(.WIDTH(V_VALUE_WIDTH), .AWIDTH(FIFO_AWIDTH), .MARGIN(PROG_FULL_MARGIN)) u_val (
    .clk(clk), .rst(rst),
    .wr_en(front_hbm_active_v_value_valid), .wr_data(front_hbm_active_v_value),
    .rd_en(pop_val), .rd_data(val_top),
    .empty(val_empty), .full(val_full), .prog_full(val_pf),
    .free_cnt(val_free), .overflow(val_ovf)
  );

  // RSP mirrors REQ depth, so only REQ and VAL throttle the reader.
  logic unused_fifo_status;
  assign unused_fifo_status = ^{req_full, rsp_full, val_full, rsp_pf,
                                req_free, rsp_free, val_free};

  assign stage_full = req_pf | val_pf;

  // A line opening a new vertex must wait for that vertex's value.
  assign pop       = !req_empty && !rsp_empty && !combine_stage_full &&
                     (!req_top.first || !val_empty);
  assign pop_val   = pop && req_top.first;
  assign value_sel = req_top.first ? val_top : cur_value;

`ifdef DROP_EMPTY_LINE_EN
  assign emit = pop && (|req_top.mask);
`else
  assign emit = pop;
`endif

  assign fwd_end = front_iteration_end && front_iteration_end_valid &&
                   req_empty && rsp_empty && val_empty && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_valid          <= 1'b0;
      last_wr_id          <= '0;
      cur_value           <= '0;
      out_q               <= '0;
      edge_valid          <= 1'b0;
      iteration_end       <= 1'b0;
      iteration_end_valid <= 1'b0;
      iteration_id        <= '0;
      overflow_err        <= 1'b0;
    end else begin
      // A request in the same cycle as a forwarded end belongs to the next iteration.
      if (front_rd_hbm_edge_valid) begin
        last_valid <= 1'b1;
        last_wr_id <= front_hbm_active_v_id;
      end else if (fwd_end) begin
        last_valid <= 1'b0;
      end
      if (pop_val) cur_value <= val_top;
      edge_valid <= emit;
      if (emit) out_q <= '{src_id: req_top.v_id, value: value_sel,
                           dst_ids: rsp_top, mask: req_top.mask};
      iteration_end       <= fwd_end;
      iteration_end_valid <= fwd_end;
      iteration_id        <= front_iteration_id;
      if (req_ovf || rsp_ovf || val_ovf) overflow_err <= 1'b1;
    end
  end

  assign edge_src_id    = out_q.src_id;
  assign edge_src_value = out_q.value;
  assign edge_dst_id    = out_q.dst_ids;
  assign edge_mask      = out_q.mask;

endmodule
